tile_sequencer: RTL

TILE_SEQUENCER -- requirements
Module: tile_sequencer

---
 rtl/piano_pkg.sv | 45 ++++
 rtl/tile_lfsr.sv | 33 +++
 rtl/tile_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared types and constants for the tile sequencer game.
//   NUM_TILES     : number of playfield tiles / buttons
//   LFSR_TAPS     : feedback mask of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   state_e       : game FSM state encoding
//   pick_target() : maps a random index onto a tile, avoiding a repeat
//   tile_onehot() : tile index to one-hot tile mask
package piano_pkg;

    localparam int unsigned NUM_TILES   = 6;
    localparam int unsigned TILE_IDX_W  = 3;
    localparam int unsigned LFSR_W      = 8;
    localparam int unsigned SCORE_W     = 8;
    localparam int unsigned LIVES_W     = 2;
    localparam int unsigned FRAME_CNT_W = 8;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef logic [NUM_TILES-1:0]  tile_mask_t;
    typedef logic [TILE_IDX_W-1:0] tile_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PICK = 3'd1,
        ST_SHOW = 3'd2,
        ST_HIT  = 3'd3,
        ST_MISS = 3'd4,
        ST_OVER = 3'd5
    } state_e;

    // Out-of-range indices wrap onto the low tiles; a repeat of the
    // previous target is bumped to the next tile so the player always moves.
    function automatic tile_idx_t pick_target(input tile_idx_t rnd, input tile_idx_t prev);
        tile_idx_t cand;
        cand = (rnd >= tile_idx_t'(NUM_TILES)) ? rnd - tile_idx_t'(NUM_TILES) : rnd;
        if (cand == prev) begin
            cand = (cand == tile_idx_t'(NUM_TILES - 1)) ? tile_idx_t'(0) : cand + tile_idx_t'(1);
        end
        return cand;
    endfunction

    function automatic tile_mask_t tile_onehot(input tile_idx_t idx);
        return tile_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/tile_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, advanced every clock.
//   clk_d : clock
//   rst_n : asynchronous active-low reset (loads SEED)
//   rnd_o : low three LFSR bits, used as the random tile candidate
module tile_lfsr
    import piano_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic                  clk_d,
    input  logic                  rst_n,
    output logic [TILE_IDX_W-1:0] rnd_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Shift left, XOR of the tapped bits enters at bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd_o = lfsr_q[TILE_IDX_W-1:0];

endmodule

// File: rtl/tile_sequencer.sv
// Whack-a-tile game sequencer: lights one random tile, scores a correct
// press, penalises a wrong press or a frame-count timeout, and shows
// hit/miss feedback for a fixed number of frames.
//   clk_d      : pixel clock
//   rst_n      : asynchronous active-low reset
//   frame_tick : one-cycle pulse per video frame
//   btn        : debounced button levels, bit i = tile i
//   start      : level, rising edge starts a game
//   tile_lit   : one-hot lit tile mask
//   hit_flash  : hit feedback active
//   miss_flash : miss feedback active
//   score      : hits this game, saturating
//   lives      : remaining lives
//   game_over  : game finished
module tile_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned       TIMEOUT_INIT = 60,
    parameter int unsigned       TIMEOUT_MIN  = 15,
    parameter int unsigned       TIMEOUT_STEP = 3,
    parameter int unsigned       FLASH_FRAMES = 10,
    parameter int unsigned       LIVES_INIT   = 3,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
    input  logic                 clk_d,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic [NUM_TILES-1:0] btn,
    input  logic                 start,
    output logic [NUM_TILES-1:0] tile_lit,
    output logic                 hit_flash,
    output logic                 miss_flash,
    output logic [SCORE_W-1:0]   score,
    output logic [LIVES_W-1:0]   lives,
    output logic                 game_over
);

    state_e                 state_q, state_d;
    tile_mask_t             btn_q;
    logic                   start_q;
    tile_idx_t              tgt_q, tgt_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic [FRAME_CNT_W-1:0] timeout_q, timeout_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [LIVES_W-1:0]     lives_q, lives_d;
    tile_mask_t             tile_lit_q, tile_lit_d;
    logic                   hit_flash_q, hit_flash_d;
    logic                   miss_flash_q, miss_flash_d;
    logic                   game_over_q, game_over_d;

    tile_idx_t              rnd;
    tile_mask_t             press_c;
    tile_mask_t             tgt_mask_c;
    logic                   start_edge_c;

    tile_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_d (clk_d),
        .rst_n (rst_n),
        .rnd_o (rnd)
    );

    assign press_c      = btn & ~btn_q;
    assign start_edge_c = start & ~start_q;
    assign tgt_mask_c   = tile_onehot(tgt_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        score_d      = score_q;
        lives_d      = lives_q;
        tile_lit_d   = '0;
        hit_flash_d  = 1'b0;
        miss_flash_d = 1'b0;
        game_over_d  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge_c) begin
                    score_d   = '0;
                    lives_d   = LIVES_W'(LIVES_INIT);
                    timeout_d = FRAME_CNT_W'(TIMEOUT_INIT);
                    state_d   = ST_PICK;
                end
            end
            ST_PICK: begin
                tgt_d   = pick_target(rnd, tgt_q);
                cnt_d   = '0;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                // A press wins over a simultaneous timeout tick.
                if (press_c != '0) begin
                    cnt_d = '0;
                    if (press_c == tgt_mask_c) begin
                        state_d = ST_HIT;
                        if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        if (timeout_q >= FRAME_CNT_W'(TIMEOUT_MIN + TIMEOUT_STEP)) begin
                            timeout_d = timeout_q - FRAME_CNT_W'(TIMEOUT_STEP);
                        end else begin
                            timeout_d = FRAME_CNT_W'(TIMEOUT_MIN);
                        end
                    end else begin
                        state_d = ST_MISS;
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end else if (frame_tick) begin
                    if (cnt_q == timeout_q - FRAME_CNT_W'(1)) begin
                        state_d = ST_MISS;
                        lives_d = lives_q - LIVES_W'(1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + FRAME_CNT_W'(1);
                    end
                end
            end
            ST_HIT, ST_MISS: begin
                if (frame_tick) begin
                    if (cnt_q == FRAME_CNT_W'(FLASH_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = (lives_q == '0) ? ST_OVER : ST_PICK;
                    end else begin
                        cnt_d = cnt_q + FRAME_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the current state, so they lag it by one clock.
        if (state_q == ST_SHOW || state_q == ST_HIT || state_q == ST_MISS) begin
            tile_lit_d = tgt_mask_c;
        end
        hit_flash_d  = (state_q == ST_HIT);
        miss_flash_d = (state_q == ST_MISS);
        game_over_d  = (state_q == ST_OVER);
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            btn_q        <= '0;
            start_q      <= 1'b0;
            tgt_q        <= '0;
            cnt_q        <= '0;
            timeout_q    <= '0;
            score_q      <= '0;
            lives_q      <= '0;
            tile_lit_q   <= '0;
            hit_flash_q  <= 1'b0;
            miss_flash_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= btn;
            start_q      <= start;
            tgt_q        <= tgt_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            tile_lit_q   <= tile_lit_d;
            hit_flash_q  <= hit_flash_d;
            miss_flash_q <= miss_flash_d;
            game_over_q  <= game_over_d;
        end
    end

    assign tile_lit   = tile_lit_q;
    assign hit_flash  = hit_flash_q;
    assign miss_flash = miss_flash_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_over  = game_over_q;

endmodule
